// File: rtl/systolic_array_v2.sv
// Weight-stationary systolic MAC tile: handshaked weight/activation/result streams,
// run-time chunk count, rounding + saturating requantisation. Define SA_RELU_EN to clamp negatives to 0.
module systolic_array_v2 #(
  parameter int BN_NUM     = 4,
  parameter int ACCU_NUM   = 2,
  parameter int BW_ACT     = 8,
  parameter int BW_WET     = 8,
  parameter int BW_ACCU    = 32,
  parameter int MAX_CHUNKS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_start,
  input  logic [$clog2(MAX_CHUNKS):0]  cfg_chunks,
  input  logic [7:0]                   cfg_shift,
  output logic                         busy,
  input  logic                         wet_valid,
  output logic                         wet_ready,
  input  logic [ACCU_NUM*BW_WET-1:0]   wet_in,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [ACCU_NUM*BW_ACT-1:0]   act_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BW_ACT-1:0]            out_data,
  output logic [$clog2(BN_NUM)-1:0]    out_row,
  output logic                         done
);
  // state  | meaning
  // IDLE   | waiting for cfg_start
  // LOAD_W | accepting one beat of stationary lane weights
  // STREAM | accepting BN_NUM activation beats, beat r -> row r
  // DRAIN  | ACCU_NUM+1 cycles for the lane pipeline to empty
  // OUTPUT | presenting requantised rows 0..BN_NUM-1
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_OUTPUT, S_DONE} state_t;

  localparam int CW     = $clog2(MAX_CHUNKS) + 1;
  localparam int RW     = $clog2(BN_NUM);
  localparam int DW     = $clog2(ACCU_NUM + 1);
  localparam int SW     = $clog2(BW_ACCU);
  localparam int AW     = BW_ACCU + 1;
  localparam int PW     = BW_ACT + BW_WET;
  localparam int SAT_HI = 2**(BW_ACT-1) - 1;
  localparam int SAT_LO = -(2**(BW_ACT-1));
  localparam logic [RW-1:0] LAST_ROW = RW'(BN_NUM - 1);

  state_t                    state, state_nxt;
  logic [CW-1:0]             chunks_q, chunk_cnt;
  logic [7:0]                shift_q;
  logic [RW-1:0]             row_cnt;
  logic [DW-1:0]             drain_cnt;
  logic                      wet_fire, act_fire, out_fire;

  logic signed [BW_WET-1:0]  w_q      [ACCU_NUM];
  logic signed [BW_ACT-1:0]  in_act   [ACCU_NUM];
  logic                      in_vld;
  logic [RW-1:0]             in_row;
  logic signed [BW_ACT-1:0]  lane_act [ACCU_NUM];
  logic signed [PW-1:0]      prod     [ACCU_NUM];
  logic signed [BW_ACCU-1:0] psum_q   [ACCU_NUM];
  logic                      vld_q    [ACCU_NUM];
  logic [RW-1:0]             row_q    [ACCU_NUM];
  logic signed [BW_ACCU-1:0] acc      [BN_NUM];

  logic signed [BW_ACCU-1:0] acc_sel;
  logic [SW-1:0]             s_amt;
  logic signed [AW-1:0]      rq_sum, rq_shift;
  logic signed [BW_ACT-1:0]  rq_sat;

  assign wet_fire = wet_valid & wet_ready;
  assign act_fire = act_valid & act_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wet_ready = 1'b0;
    act_ready = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:
        if (cfg_start) state_nxt = (cfg_chunks == '0) ? S_OUTPUT : S_LOAD_W;
      S_LOAD_W: begin
        wet_ready = 1'b1;
        if (wet_valid) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        act_ready = 1'b1;
        if (act_valid && row_cnt == LAST_ROW) state_nxt = S_DRAIN;
      end
      S_DRAIN:
        if (drain_cnt == '0)
          state_nxt = ((chunk_cnt + CW'(1)) < chunks_q) ? S_LOAD_W : S_OUTPUT;
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && row_cnt == LAST_ROW) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // row_cnt is shared: beat index while streaming, result index while outputting
  always_ff @(posedge clk) begin
    if (reset) begin
      chunks_q  <= '0;
      shift_q   <= '0;
      chunk_cnt <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      for (int k = 0; k < ACCU_NUM; k++) w_q[k] <= '0;
    end else begin
      if (state == S_IDLE && cfg_start) begin
        chunks_q  <= cfg_chunks;
        shift_q   <= cfg_shift;
        chunk_cnt <= '0;
        row_cnt   <= '0;
      end
      if (wet_fire)
        for (int k = 0; k < ACCU_NUM; k++) w_q[k] <= wet_in[k*BW_WET +: BW_WET];
      if (act_fire || out_fire)
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
      if (act_fire && row_cnt == LAST_ROW)
        drain_cnt <= DW'(ACCU_NUM);
      else if (state == S_DRAIN) begin
        if (drain_cnt == '0) chunk_cnt <= chunk_cnt + CW'(1);
        else                 drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  // Lane k sees its activation k cycles after lane 0, in step with the rippling partial sum
  for (genvar k = 0; k < ACCU_NUM; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign lane_act[k] = in_act[k];
    end else begin : g_skew
      logic signed [BW_ACT-1:0] skew_q [k];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < k; i++) skew_q[i] <= '0;
        end else begin
          skew_q[0] <= in_act[k];
          for (int i = 1; i < k; i++) skew_q[i] <= skew_q[i-1];
        end
      end
      assign lane_act[k] = skew_q[k-1];
    end
    assign prod[k] = lane_act[k] * w_q[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld <= 1'b0;
      in_row <= '0;
      for (int k = 0; k < ACCU_NUM; k++) begin
        in_act[k] <= '0;
        psum_q[k] <= '0;
        vld_q[k]  <= 1'b0;
        row_q[k]  <= '0;
      end
      for (int r = 0; r < BN_NUM; r++) acc[r] <= '0;
    end else begin
      in_vld <= act_fire;
      if (act_fire) begin
        in_row <= row_cnt;
        for (int k = 0; k < ACCU_NUM; k++) in_act[k] <= act_in[k*BW_ACT +: BW_ACT];
      end
      psum_q[0] <= BW_ACCU'(prod[0]);
      vld_q[0]  <= in_vld;
      row_q[0]  <= in_row;
      for (int k = 1; k < ACCU_NUM; k++) begin
        psum_q[k] <= psum_q[k-1] + BW_ACCU'(prod[k]);
        vld_q[k]  <= vld_q[k-1];
        row_q[k]  <= row_q[k-1];
      end
      if (state == S_IDLE && cfg_start) begin
        for (int r = 0; r < BN_NUM; r++) acc[r] <= '0;
      end else if (vld_q[ACCU_NUM-1]) begin
        acc[row_q[ACCU_NUM-1]] <= acc[row_q[ACCU_NUM-1]] + psum_q[ACCU_NUM-1];
      end
    end
  end

  // One guard bit above the accumulator keeps the rounding add from overflowing
  always_comb begin
    acc_sel  = acc[row_cnt];
    s_amt    = (shift_q > 8'(BW_ACCU-1)) ? SW'(BW_ACCU-1) : shift_q[SW-1:0];
    rq_sum   = {acc_sel[BW_ACCU-1], acc_sel};
    if (s_amt != '0) rq_sum = rq_sum + (AW'(1) << (s_amt - SW'(1)));
    rq_shift = rq_sum >>> s_amt;
    if (rq_shift > AW'(SAT_HI))      rq_sat = BW_ACT'(SAT_HI);
    else if (rq_shift < AW'(SAT_LO)) rq_sat = BW_ACT'(SAT_LO);
    else                             rq_sat = rq_shift[BW_ACT-1:0];
`ifdef SA_RELU_EN
    if (rq_sat[BW_ACT-1]) rq_sat = '0;
`else
    rq_sat = rq_sat;
`endif
  end

  assign busy     = (state != S_IDLE);
  assign out_data = out_valid ? rq_sat : '0;
  assign out_row  = out_valid ? row_cnt : '0;

endmodule

// File: tb/tb_systolic_array_v2.sv
// Directed bench for systolic_array_v2: table of jobs with hand-computed results,
// plus backpressure, busy-start and mid-job reset sequences.
module tb_systolic_array_v2;
  logic        clk = 1'b0;
  logic        reset, cfg_start, wet_valid, act_valid, out_ready;
  logic [4:0]  cfg_chunks;
  logic [7:0]  cfg_shift;
  logic [15:0] wet_in, act_in;
  logic        busy, wet_ready, act_ready, out_valid, done;
  logic [7:0]  out_data;
  logic [1:0]  out_row;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_array_v2 dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_chunks(cfg_chunks),
    .cfg_shift(cfg_shift), .busy(busy), .wet_valid(wet_valid), .wet_ready(wet_ready),
    .wet_in(wet_in), .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .done(done)
  );

  typedef struct packed {
    logic [4:0]            chunks;
    logic [7:0]            shift;
    logic [3:0]            gap;
    logic [1:0][15:0]      w;      // [chunk] = {lane1, lane0}
    logic [1:0][3:0][15:0] a;      // [chunk][row] = {lane1, lane0}
    logic [3:0][7:0]       expv;   // [row]
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] pk(input int l0, input int l1);
    return {8'(l1), 8'(l0)};
  endfunction

  function automatic logic [63:0] rows4(input logic [15:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [31:0] ex4(input int e0, e1, e2, e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic timed_out(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, " busy"},      int'(busy), 0);
    chk({nm, " wet_ready"}, int'(wet_ready), 0);
    chk({nm, " act_ready"}, int'(act_ready), 0);
    chk({nm, " out_valid"}, int'(out_valid), 0);
    chk({nm, " done"},      int'(done), 0);
    chk({nm, " out_data"},  int'(out_data), 0);
    chk({nm, " out_row"},   int'(out_row), 0);
  endtask

  task automatic start_job(input logic [4:0] ch, input logic [7:0] sh);
    cfg_chunks = ch;
    cfg_shift  = sh;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    chk("busy after start", int'(busy), 1);
  endtask

  task automatic send_wet(input logic [15:0] w, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    wet_in = w;
    wet_valid = 1'b1;
    n = 0;
    while (!wet_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timed_out("wet handshake");
    @(negedge clk);
    wet_valid = 1'b0;
    wet_in = 16'h5A5A;
  endtask

  task automatic send_act(input logic [15:0] a, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    act_in = a;
    act_valid = 1'b1;
    n = 0;
    while (!act_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timed_out("act handshake");
    @(negedge clk);
    act_valid = 1'b0;
    act_in = 16'h3C3C;
  endtask

  task automatic collect(input vec_t v, input int vi, input int bp_row);
    int n;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
        timed_out($sformatf("v%0d out_valid row %0d", vi, r));
        return;
      end
      chk($sformatf("v%0d row%0d out_row", vi, r), int'(out_row), r);
      chk($sformatf("v%0d row%0d out_data", vi, r), int'($signed(out_data)), int'($signed(v.expv[r])));
      if (r == bp_row) begin
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("v%0d hold out_valid", vi), int'(out_valid), 1);
          chk($sformatf("v%0d hold out_row", vi), int'(out_row), r);
          chk($sformatf("v%0d hold out_data", vi), int'($signed(out_data)), int'($signed(v.expv[r])));
        end
      end
      repeat ($urandom_range(int'(v.gap), 0)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk($sformatf("v%0d done pulse", vi), int'(done), 1);
    @(negedge clk);
    chk($sformatf("v%0d done low", vi), int'(done), 0);
    chk($sformatf("v%0d idle busy", vi), int'(busy), 0);
  endtask

  task automatic run_job(input vec_t v, input int vi, input int bp_row);
    start_job(v.chunks, v.shift);
    for (int c = 0; c < int'(v.chunks); c++) begin
      send_wet(v.w[c], $urandom_range(int'(v.gap), 0));
      for (int r = 0; r < 4; r++) send_act(v.a[c][r], $urandom_range(int'(v.gap), 0));
    end
    collect(v, vi, bp_row);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    vecs[0].chunks = 5'd1; vecs[0].shift = 8'd0; vecs[0].gap = 4'd0;
    vecs[0].w[0]   = pk(1, 2);
    vecs[0].a[0]   = rows4(pk(1, 1), pk(2, 3), pk(-1, 0), pk(4, -2));
    vecs[0].expv   = ex4(3, 8, -1, 0);

    vecs[1]        = vecs[0];
    vecs[1].chunks = 5'd2; vecs[1].gap = 4'd3;
    vecs[1].w[1]   = pk(1, 1);
    vecs[1].a[1]   = rows4(pk(1, 1), pk(1, 1), pk(1, 1), pk(1, 1));
    vecs[1].expv   = ex4(5, 10, 1, 2);

    vecs[2].chunks = 5'd1; vecs[2].shift = 8'd0; vecs[2].gap = 4'd1;
    vecs[2].w[0]   = pk(127, 127);
    vecs[2].a[0]   = rows4(pk(127, 127), pk(-128, -128), pk(127, -128), pk(0, 1));
    vecs[2].expv   = ex4(127, -128, -127, 127);

    vecs[3].chunks = 5'd1; vecs[3].shift = 8'd2; vecs[3].gap = 4'd1;
    vecs[3].w[0]   = pk(1, 1);
    vecs[3].a[0]   = rows4(pk(3, 3), pk(-3, -3), pk(1, 0), pk(2, 0));
    vecs[3].expv   = ex4(2, -1, 0, 1);

    vecs[4].chunks = 5'd1; vecs[4].shift = 8'd40; vecs[4].gap = 4'd0;
    vecs[4].w[0]   = pk(127, 127);
    vecs[4].a[0]   = rows4(pk(127, 127), pk(-128, -128), pk(-128, 127), pk(0, 0));
    vecs[4].expv   = ex4(0, 0, 0, 0);

    vecs[5].chunks = 5'd0; vecs[5].shift = 8'd0; vecs[5].gap = 4'd2;
    vecs[5].expv   = ex4(0, 0, 0, 0);

    reset = 1'b1; cfg_start = 1'b0; cfg_chunks = '0; cfg_shift = '0;
    wet_valid = 1'b0; wet_in = '0; act_valid = 1'b0; act_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], i, -1);

    // result backpressure held on row 1
    run_job(vecs[0], 10, 1);

    // stray act_valid in LOAD_W and cfg_start mid-job are both ignored
    start_job(5'd1, 8'd0);
    act_in = pk(100, 100);
    act_valid = 1'b1;
    @(negedge clk);
    chk("stray act_ready", int'(act_ready), 0);
    act_valid = 1'b0;
    send_wet(vecs[0].w[0], 0);
    cfg_chunks = 5'd0; cfg_shift = 8'd3; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy start ignored", int'(busy), 1);
    for (int r = 0; r < 4; r++) send_act(vecs[0].a[0][r], 0);
    collect(vecs[0], 11, -1);

    // reset while streaming abandons the job without a done pulse
    start_job(5'd1, 8'd0);
    send_wet(vecs[0].w[0], 0);
    send_act(vecs[0].a[0][0], 0);
    send_act(vecs[0].a[0][1], 0);
    act_in = vecs[0].a[0][2];
    act_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("mid-job reset");
    reset = 1'b0;
    act_valid = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("no activity after reset", int'(seen_done), 0);
    run_job(vecs[0], 12, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_array_v2.md
Name: systolic_array_v2

Overview:
- Second-generation weight-stationary systolic MAC tile: BN_NUM output rows × ACCU_NUM MAC lanes, with its own control FSM.
- Generalises v1 in three ways:
  - valid/ready handshakes on all streams replace testbench-driven control pins.
  - Internal activation skewing.
  - Multi-chunk reduction depth set at run time, with rounding and saturating requantisation.
- Sits between the on-chip act/weight buffers and the output-activation writeback.

Parameters:
- BN_NUM, 4: output rows per tile (accumulators).
- ACCU_NUM, 2: MAC lanes, i.e. elements reduced per beat.
- BW_ACT, 8: activation and output width, signed.
- BW_WET, 8: weight width, signed.
- BW_ACCU, 32: accumulator width, signed.
- MAX_CHUNKS, 16: maximum reduction chunks per job.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  job start; sampled only in IDLE.
- cfg_chunks  in  $clog2(MAX_CHUNKS)+1  number of ACCU_NUM-wide chunks; latched at start.
- cfg_shift  in  8  requantisation right-shift; latched at start.
- busy  out  1  high in every state except IDLE.
- wet_valid  in  1  weight beat valid.
- wet_ready  out  1  weight beat ready.
- wet_in  in  ACCU_NUM*BW_WET  packed lane weights; lane k at bits [k*BW_WET +: BW_WET].
- act_valid  in  1  activation beat valid.
- act_ready  out  1  activation beat ready.
- act_in  in  ACCU_NUM*BW_ACT  one output row's ACCU_NUM activations for the current chunk.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  BW_ACT  requantised result.
- out_row  out  $clog2(BN_NUM)  row index of out_data.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset:
  - FSM returns to IDLE; all accumulators, skew registers and pipeline registers clear to 0.
  - busy, wet_ready, act_ready, out_valid and done are all 0; out_data = 0 and out_row = 0.
  - Reset mid-job abandons the job; no done pulse is produced.
- States:
  - IDLE:
    - cfg_start=1: latch cfg, clear accumulators, chunk_cnt=0.
    - Next state is LOAD_W, or OUTPUT if cfg_chunks==0.
  - LOAD_W:
    - wet_ready=1.
    - On wet_valid&wet_ready, latch ACCU_NUM stationary weights → STREAM.
  - STREAM:
    - act_ready=1.
    - Accepts exactly BN_NUM beats; beat r belongs to row r.
    - Gaps between beats are allowed.
    - After beat BN_NUM-1 → DRAIN.
  - DRAIN:
    - Waits exactly ACCU_NUM+1 cycles for the pipeline to empty.
    - chunk_cnt++; then LOAD_W if chunk_cnt<cfg_chunks, else OUTPUT.
  - OUTPUT:
    - Presents rows 0..BN_NUM-1 in order.
    - out_data and out_row are held stable while out_valid & !out_ready.
    - After the last handshake → DONE.
  - DONE: done=1 for one cycle → IDLE.
- cfg_start outside IDLE is ignored.
- valid signals are ignored while the matching ready is 0.
- Datapath:
  - Lane k input is delayed k cycles (skew).
  - Partial sums ripple lane 0 → ACCU_NUM-1, one register per lane.
  - Each accepted beat's accumulator update lands exactly ACCU_NUM+1 cycles after acceptance.
- Arithmetic:
  - product = signed act × signed weight (BW_ACT+BW_WET bits), sign-extended to BW_ACCU.
  - Accumulation wraps modulo 2^BW_ACCU.
- Requantisation, with s = min(cfg_shift, BW_ACCU-1):
  - r = (acc + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in BW_ACCU+1 bits (round half up).
  - r is then saturated to [-2^(BW_ACT-1), 2^(BW_ACT-1)-1].

Optional Feature:
- SA_RELU_EN defined: after saturation, negative results are output as 0.
- Undefined: signed results pass through unchanged.

Test Plan:
- Single chunk (BN_NUM=4, ACCU_NUM=2, shift 0):
  - Stimulus: weights (1,2); act rows (1,1),(2,3),(-1,0),(4,-2).
  - Response: outputs 3, 8, -1, 0 on rows 0..3, then one done pulse.
- Two chunks:
  - Stimulus: the previous job plus a second chunk with weights (1,1) and all act rows (1,1); random valid gaps on both streams.
  - Response: 5, 10, 1, 2.
- Saturation and rounding:
  - Weights (127,127) with all acts 127 → 127.
  - Acts -128 → -128.
  - shift=2 with acc 6 → 2; acc -6 → -1.
  - shift=40 is treated as 31.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles on row 1.
  - Response: out_data and out_row stable; no row skipped or duplicated.
- Control edge cases:
  - cfg_chunks=0 → four zeros then done.
  - cfg_start while busy → no effect.
  - reset during STREAM → IDLE next cycle, all outputs 0; a new job then gives the correct results.
- With SA_RELU_EN defined, the single-chunk job → 3, 8, 0, 0.
